io_axil_arbiter: RTL

Two-requester arbiter that shares the single AXI4-Lite slave port of the IO register block. Each requester issues single-word read or write commands over a valid/ack interface. The block grants requesters round-robin and runs exactly one AXI4-Lite transaction at a time on its master port. It returns read data and the response code to the granted requester. It sits between on-chip command sources (for example, a sequencer and a CPU bridge) and the IO slave's S00_AXI port.

---
 rtl/io_axil_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/io_axil_arbiter.sv
// ---------------------------------------------------------------------------
// io_axil_arbiter
//
// Shares one AXI4-Lite master port between two command requesters. Commands
// are single-word reads or writes. Requesters are granted round-robin, and
// exactly one AXI4-Lite transaction is in flight at any time.
//
// Handshake semantics: a transfer happens on a rising ACLK edge where VALID
// and READY are both high. VALID, once raised, stays high until that edge.
// On the requester side, req_valid[i] plus payload must be held until the
// req_ack[i] pulse. rsp_valid[i] is a one-cycle pulse with no back-pressure.
//
// Ports:
//   ACLK, ARESETN      clock, asynchronous active-low reset
//   req_valid/we       per-requester command valid / write-enable (bit i)
//   req_addr/wdata     per-requester address / write data (packed slices)
//   req_ack            one-cycle pulse when command i is accepted
//   rsp_valid          one-cycle pulse when command i completes
//   rsp_rdata/resp     read data (0 for writes) and BRESP/RRESP
//   M_AXI_*            AXI4-Lite master port
//   dbg_state          current FSM state, for observation only
// ---------------------------------------------------------------------------
module io_axil_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ack,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                  state, state_n;
    logic                    grant, grant_n;
    logic                    last, last_n;
    logic [ADDR_WIDTH-1:0]   cmd_addr, cmd_addr_n;
    logic [DATA_WIDTH-1:0]   cmd_wdata, cmd_wdata_n;
    logic [DATA_WIDTH-1:0]   data_q, data_n;
    logic [1:0]              resp_q, resp_n;
    logic                    awvalid_q, awvalid_n;
    logic                    wvalid_q, wvalid_n;
    logic                    bready_q, bready_n;
    logic                    arvalid_q, arvalid_n;
    logic                    rready_q, rready_n;
    logic [1:0]              ack_q, ack_n;
    logic [1:0]              rspv_q, rspv_n;
    logic [DATA_WIDTH-1:0]   rspd_q, rspd_n;
    logic [1:0]              rspr_q, rspr_n;
    logic                    pick;
    logic                    aw_pending, w_pending;

    // On a tie the requester that did not win last time is chosen; a lone
    // requester always wins.
    assign pick = (req_valid == 2'b11) ? ~last : req_valid[1];

    // Channels still waiting for their handshake after this edge.
    assign aw_pending = awvalid_q & ~M_AXI_AWREADY;
    assign w_pending  = wvalid_q & ~M_AXI_WREADY;

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        last_n      = last;
        cmd_addr_n  = cmd_addr;
        cmd_wdata_n = cmd_wdata;
        data_n      = data_q;
        resp_n      = resp_q;
        awvalid_n   = awvalid_q;
        wvalid_n    = wvalid_q;
        bready_n    = 1'b0;
        arvalid_n   = arvalid_q;
        rready_n    = 1'b0;
        ack_n       = 2'b00;
        rspv_n      = 2'b00;
        rspd_n      = '0;
        rspr_n      = 2'b00;

        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_n     = pick;
                    cmd_addr_n  = pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                       : req_addr[ADDR_WIDTH-1:0];
                    cmd_wdata_n = pick ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                       : req_wdata[DATA_WIDTH-1:0];
                    ack_n       = pick ? 2'b10 : 2'b01;
                    if (req_we[pick]) begin
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        state_n   = WRITE;
                    end else begin
                        arvalid_n = 1'b1;
                        state_n   = READ;
                    end
                end
            end
            WRITE: begin
                // AW and W retire independently; leave once neither is pending.
                if (awvalid_q && M_AXI_AWREADY) awvalid_n = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_n  = 1'b0;
                if (!aw_pending && !w_pending) begin
                    bready_n = 1'b1;
                    state_n  = WRESP;
                end
            end
            WRESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    resp_n  = M_AXI_BRESP;
                    data_n  = '0;
                    state_n = DONE;
                end else begin
                    bready_n = 1'b1;
                end
            end
            READ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RDATA;
                end
            end
            RDATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    data_n  = M_AXI_RDATA;
                    resp_n  = M_AXI_RRESP;
                    state_n = DONE;
                end else begin
                    rready_n = 1'b1;
                end
            end
            DONE: begin
                rspv_n  = grant ? 2'b10 : 2'b01;
                rspd_n  = data_q;
                rspr_n  = resp_q;
                last_n  = grant;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            grant     <= 1'b0;
            last      <= 1'b1;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            data_q    <= '0;
            resp_q    <= 2'b00;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 2'b00;
            rspv_q    <= 2'b00;
            rspd_q    <= '0;
            rspr_q    <= 2'b00;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            last      <= last_n;
            cmd_addr  <= cmd_addr_n;
            cmd_wdata <= cmd_wdata_n;
            data_q    <= data_n;
            resp_q    <= resp_n;
            awvalid_q <= awvalid_n;
            wvalid_q  <= wvalid_n;
            bready_q  <= bready_n;
            arvalid_q <= arvalid_n;
            rready_q  <= rready_n;
            ack_q     <= ack_n;
            rspv_q    <= rspv_n;
            rspd_q    <= rspd_n;
            rspr_q    <= rspr_n;
        end
    end

    assign req_ack       = ack_q;
    assign rsp_valid     = rspv_q;
    assign rsp_rdata     = rspd_q;
    assign rsp_resp      = rspr_q;
    assign M_AXI_AWADDR  = cmd_addr;
    assign M_AXI_ARADDR  = cmd_addr;
    assign M_AXI_WDATA   = cmd_wdata;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign dbg_state     = state;

endmodule
